// File: rtl/fifo_arb_pkg.sv
// Shared constants for the FIFO write arbiter: lock FSM encoding and an index-width helper.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set bit of req at or above ptr, wrapping modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  // NOTE: every output gets a default before the search so no latch is inferred.
  always_comb begin
    int k;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    k   = 0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      if (!any && req[k]) begin
        any    = 1'b1;
        idx    = k[IW-1:0];
        gnt[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers, with burst lock
// and a registered write stage throttled by the FIFO's full/almost_full flags.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int IDX_WIDTH  = clog2(N_REQ)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_i,
  input  logic [N_REQ*DATA_WIDTH-1:0] data_i,
  input  logic [N_REQ-1:0]            last_i,
  output logic [N_REQ-1:0]            gnt_o,
  input  logic                        fifo_full_i,
  input  logic                        fifo_almost_full_i,
  output logic                        fifo_wr_en_o,
  output logic [DATA_WIDTH-1:0]       fifo_data_o,
  output logic                        lock_o,
  output logic [IDX_WIDTH-1:0]        lock_idx_o
);

  arb_state_e           state;
  logic [IDX_WIDTH-1:0] prio_ptr;
  logic [IDX_WIDTH-1:0] lock_idx;
  logic [N_REQ-1:0]     lock_mask;
  logic [N_REQ-1:0]     cand_req;
  logic [N_REQ-1:0]     pick_gnt;
  logic [IDX_WIDTH-1:0] pick_idx;
  logic                 pick_any;
  logic                 space_ok;
  logic                 xfer;
  logic                 last_sel;
  logic [DATA_WIDTH-1:0] data_sel;

  // The registered write from the previous cycle is not yet in the FIFO's count,
  // so almost_full plus a pending write already means no room.
  assign space_ok = !fifo_full_i && !(fifo_almost_full_i && fifo_wr_en_o);

  always_comb begin
    lock_mask           = '0;
    lock_mask[lock_idx] = 1'b1;
  end

  assign cand_req = (state == ARB_LOCKED) ? (req_i & lock_mask) : req_i;

  rr_pick #(
    .N  (N_REQ),
    .IW (IDX_WIDTH)
  ) u_pick (
    .req (cand_req),
    .ptr (prio_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign xfer     = pick_any && space_ok && rst_n;
  assign gnt_o    = xfer ? pick_gnt : '0;
  assign last_sel = last_i[pick_idx];
  assign data_sel = data_i[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ARB_IDLE;
      prio_ptr     <= '0;
      lock_idx     <= '0;
      fifo_wr_en_o <= 1'b0;
      fifo_data_o  <= '0;
    end else begin
      fifo_wr_en_o <= xfer;
      if (xfer) begin
        fifo_data_o <= data_sel;
        if (last_sel) begin
          state    <= ARB_IDLE;
          prio_ptr <= (pick_idx == IDX_WIDTH'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
        end else begin
          state    <= ARB_LOCKED;
          lock_idx <= pick_idx;
        end
      end
    end
  end

  assign lock_o     = (state == ARB_LOCKED);
  assign lock_idx_o = lock_idx;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized scoreboard bench for fifo_wr_arbiter against a behavioural FIFO and a
// rule-level arbitration model.
module tb_fifo_wr_arbiter;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int IW    = 2;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_i = '0;
  logic [N*DW-1:0] data_i = '0;
  logic [N-1:0]    last_i = '0;
  logic [N-1:0]    gnt_o;
  logic            fifo_full_i = 1'b0;
  logic            fifo_almost_full_i = 1'b0;
  logic            fifo_wr_en_o;
  logic [DW-1:0]   fifo_data_o;
  logic            lock_o;
  logic [IW-1:0]   lock_idx_o;

  fifo_wr_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .IDX_WIDTH(IW)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .req_i              (req_i),
    .data_i             (data_i),
    .last_i             (last_i),
    .gnt_o              (gnt_o),
    .fifo_full_i        (fifo_full_i),
    .fifo_almost_full_i (fifo_almost_full_i),
    .fifo_wr_en_o       (fifo_wr_en_o),
    .fifo_data_o        (fifo_data_o),
    .lock_o             (lock_o),
    .lock_idx_o         (lock_idx_o)
  );

  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_fail = 0;
  logic [DW-1:0] sb[$];

  // Reference state: next-priority producer, burst owner (-1 when free), write in flight.
  int  m_ptr = 0;
  int  m_owner = -1;
  bit  m_pend = 1'b0;
  // Behavioural FIFO occupancy and the write/read that land on the coming edge.
  int  f_cnt = 0;
  bit  wr_s = 1'b0;
  bit  rd_s = 1'b0;
  bit  rd = 1'b0;
  bit  adv[N];
  int  stall[N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && fifo_wr_en_o === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_write: got data 0x%0h expected no write at %0t", fifo_data_o, $time);
      end else begin
        logic [DW-1:0] e;
        e = sb.pop_front();
        check("fifo_data", 32'(fifo_data_o), 32'(e));
      end
    end
  end

  function automatic int exp_grant();
    if (f_cnt + int'(m_pend) >= DEPTH) return -1;
    if (m_owner >= 0) return req_i[m_owner] ? m_owner : -1;
    for (int i = 0; i < N; i++) begin
      int k;
      k = (m_ptr + i) % N;
      if (req_i[k]) return k;
    end
    return -1;
  endfunction

  task automatic set_flags();
    fifo_full_i        = (f_cnt >= DEPTH);
    fifo_almost_full_i = (f_cnt >= DEPTH - 1);
  endtask

  task automatic new_word(input int k, input int p_req, input int p_last);
    req_i[k]              = ($urandom_range(99) < p_req);
    data_i[k*DW +: DW]    = DW'($urandom);
    last_i[k]             = ($urandom_range(99) < p_last);
  endtask

  // Each iteration starts half a cycle before an edge: check and predict, then
  // let the edge happen, then update the FIFO and the producers.
  task automatic run(input int cycles, input int p_req, input int p_last,
                     input int p_drop, input int rd_mode);
    for (int c = 0; c < cycles; c++) begin
      int g;
      check("no_write_when_full", 32'(fifo_wr_en_o && fifo_full_i), 32'd0);
      check("lock", 32'(lock_o), 32'(m_owner >= 0));
      if (m_owner >= 0) check("lock_idx", 32'(lock_idx_o), 32'(m_owner));
      g = exp_grant();
      check("gnt", 32'(gnt_o), (g < 0) ? 32'd0 : (32'd1 << g));
      if (g >= 0) begin
        sb.push_back(data_i[g*DW +: DW]);
        if (last_i[g]) begin
          m_owner = -1;
          m_ptr   = (g + 1) % N;
        end else begin
          m_owner = g;
        end
      end
      m_pend = (g >= 0);
      for (int k = 0; k < N; k++) adv[k] = req_i[k] && gnt_o[k];
      wr_s = fifo_wr_en_o;
      rd_s = rd;

      @(posedge clk);
      #1;
      f_cnt = f_cnt + int'(wr_s) - int'(rd_s);
      set_flags();
      case (rd_mode)
        1:       rd = (f_cnt > 0);
        2:       rd = (f_cnt > 0) && ($urandom_range(1) == 1);
        3:       rd = (f_cnt > 0) && (c == 0);
        default: rd = 1'b0;
      endcase
      for (int k = 0; k < N; k++) begin
        if (stall[k] > 0) begin
          stall[k]--;
          req_i[k] = 1'b0;
        end else if (adv[k] || !req_i[k]) begin
          new_word(k, p_req, p_last);
        end else if ($urandom_range(99) < p_drop) begin
          req_i[k] = 1'b0;
          stall[k] = 5;
        end
      end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clear_env();
    req_i   = '0;
    last_i  = '0;
    sb.delete();
    m_ptr   = 0;
    m_owner = -1;
    m_pend  = 1'b0;
    f_cnt   = 0;
    wr_s    = 1'b0;
    rd_s    = 1'b0;
    rd      = 1'b0;
    for (int k = 0; k < N; k++) begin
      adv[k]   = 1'b0;
      stall[k] = 0;
    end
    set_flags();
  endtask

  task automatic do_reset(input bit mid);
    if (mid) begin
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("rst_wr_en", 32'(fifo_wr_en_o), 32'd0);
      check("rst_lock", 32'(lock_o), 32'd0);
      check("rst_lock_idx", 32'(lock_idx_o), 32'd0);
      check("rst_data", 32'(fifo_data_o), 32'd0);
    end else begin
      rst_n = 1'b0;
    end
    clear_env();
    req_i = '1;
    #1;
    check("rst_gnt", 32'(gnt_o), 32'd0);
    req_i = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_wr_en_hold", 32'(fifo_wr_en_o), 32'd0);
    check("rst_data_hold", 32'(fifo_data_o), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset(1'b0);

    // Fairness: everyone requesting single-word bursts, FIFO drained every cycle.
    run(12, 100, 100, 0, 1);
    // Full throttle: no reads, exactly DEPTH words accepted.
    run(12, 100, 100, 0, 0);
    check("fifo_filled", 32'(f_cnt), 32'(DEPTH));
    // One read pulse frees exactly one slot.
    run(4, 100, 100, 0, 3);
    check("fifo_refilled", 32'(f_cnt), 32'(DEPTH));
    run(8, 0, 100, 0, 1);

    // Mixed bursts, random reads, then owners stalling mid-burst.
    run(300, 70, 30, 0, 2);
    run(200, 80, 20, 10, 2);

    // Long bursts, then an asynchronous reset in the middle of one.
    run(20, 100, 0, 0, 1);
    do_reset(1'b1);
    run(8, 100, 100, 0, 1);
    run(200, 60, 40, 15, 2);

    // Drain: no new words; all accepted words must have reached the FIFO.
    run(30, 0, 100, 0, 1);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
